// File: rtl/vst_pkg.sv
// Shared definitions for the variable state table: row addresses, sizes and the row bundle.
package vst_pkg;

  localparam int unsigned VAR_NUM = 16;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned LVL_W   = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W   = $clog2(DEPTH);

  localparam logic [1:0] VST_FREE   = 2'd0;
  localparam logic [1:0] VST_ASSIGN = 2'd1;
  localparam logic [1:0] VST_FORCE  = 2'd2;
  localparam logic [1:0] VST_STATUS = 2'd3;

  typedef struct packed {
    logic [VAR_NUM-1:0] free;
    logic [VAR_NUM-1:0] assignment;
    logic [VAR_NUM-1:0] force_assign;
  } vst_rows_t;

  localparam vst_rows_t VST_ROWS_RST = '{
    free:         {VAR_NUM{1'b1}},
    assignment:   {VAR_NUM{1'b0}},
    force_assign: {VAR_NUM{1'b0}}
  };

endpackage

// File: rtl/vst_snapshot_stack.sv
// Bounded LIFO of row snapshots, one entry per decision level.
module vst_snapshot_stack
  import vst_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  vst_rows_t        din,
  output vst_rows_t        top_c,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             err
);

  vst_rows_t        mem [DEPTH];
  logic             push_ok_c;
  logic             pop_ok_c;
  logic             err_c;
  logic [LVL_W-1:0] level_nxt_c;

  // Accept/reject decision and next occupancy
  always_comb begin
    push_ok_c   = push & ~pop & ~full;
    pop_ok_c    = pop & ~push & ~empty;
    err_c       = (push & pop) | (push & full) | (pop & empty);
    level_nxt_c = level;
    if (push_ok_c) begin
      level_nxt_c = level + LVL_W'(1);
    end else if (pop_ok_c) begin
      level_nxt_c = level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      err   <= 1'b0;
    end else if (clear) begin
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      err   <= 1'b0;
    end else begin
      level <= level_nxt_c;
      full  <= (level_nxt_c == LVL_W'(DEPTH));
      empty <= (level_nxt_c == '0);
      err   <= err_c;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push_ok_c && !clear) begin
      mem[IDX_W'(level)] <= din;
    end
  end

  assign top_c = mem[IDX_W'(level - LVL_W'(1))];

endmodule

// File: rtl/var_state_table.sv
// Variable state table: live free/assignment/force rows, BCP merge writes, and snapshot stack.
module var_state_table
  import vst_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               vst_en,
  input  logic               vst_write,
  input  logic               vst_bcp_write,
  input  logic [1:0]         vst_address,
  input  logic [VAR_NUM-1:0] vst_in,
  output logic [VAR_NUM-1:0] vst_out,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  output logic [LVL_W-1:0]   level,
  output logic               full,
  output logic               empty,
  output logic               stack_err
);

  vst_rows_t          rows;
  vst_rows_t          rows_nxt_c;
  vst_rows_t          top_c;
  logic               restore_c;
  logic [VAR_NUM-1:0] rd_c;

  vst_snapshot_stack u_stack (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (rows),
    .top_c (top_c),
    .level (level),
    .full  (full),
    .empty (empty),
    .err   (stack_err)
  );

  // Row update: full write beats merge; an accepted pop overrides both
  always_comb begin
    rows_nxt_c = rows;
    restore_c  = pop & ~push & ~empty;
    if (vst_en && vst_write) begin
      case (vst_address)
        VST_FREE:   rows_nxt_c.free         = vst_in;
        VST_ASSIGN: rows_nxt_c.assignment   = vst_in;
        VST_FORCE:  rows_nxt_c.force_assign = vst_in;
        default:    ;
      endcase
    end else if (vst_en && vst_bcp_write) begin
      case (vst_address)
        VST_FREE:   rows_nxt_c.free         = rows.free & ~vst_in;
        VST_ASSIGN: rows_nxt_c.assignment   = (rows.assignment & ~rows.free) | (vst_in & rows.free);
        VST_FORCE:  rows_nxt_c.force_assign = rows.force_assign | vst_in;
        default:    ;
      endcase
    end
    if (restore_c) begin
      rows_nxt_c = top_c;
    end
  end

  // Read mux sees pre-update state
  always_comb begin
    rd_c = '0;
    case (vst_address)
      VST_FREE:   rd_c = rows.free;
      VST_ASSIGN: rd_c = rows.assignment;
      VST_FORCE:  rd_c = rows.force_assign;
      VST_STATUS: rd_c = VAR_NUM'({level, full, empty});
      default:    rd_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows    <= VST_ROWS_RST;
      vst_out <= '0;
    end else if (clear) begin
      rows    <= VST_ROWS_RST;
      vst_out <= '0;
    end else begin
      rows <= rows_nxt_c;
      if (vst_en) begin
        vst_out <= rd_c;
      end
    end
  end

endmodule

// File: tb/tb_var_state_table.sv
// Scoreboard bench for var_state_table: driver queues expectations, monitor checks after each edge.
module tb_var_state_table;
  import vst_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               vst_en = 1'b0;
  logic               vst_write = 1'b0;
  logic               vst_bcp_write = 1'b0;
  logic [1:0]         vst_address = 2'd0;
  logic [VAR_NUM-1:0] vst_in = '0;
  logic [VAR_NUM-1:0] vst_out;
  logic               push = 1'b0;
  logic               pop = 1'b0;
  logic               clear = 1'b0;
  logic [LVL_W-1:0]   level;
  logic               full;
  logic               empty;
  logic               stack_err;

  typedef struct {
    string       name;
    logic        chk_out;
    logic [15:0] out;
    logic [3:0]  lvl;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  var_state_table dut (
    .clk           (clk),
    .rst           (rst),
    .vst_en        (vst_en),
    .vst_write     (vst_write),
    .vst_bcp_write (vst_bcp_write),
    .vst_address   (vst_address),
    .vst_in        (vst_in),
    .vst_out       (vst_out),
    .push          (push),
    .pop           (pop),
    .clear         (clear),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .stack_err     (stack_err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One cycle of stimulus, issued at a falling edge, with the state expected after the next rising edge
  task automatic step(input logic en, input logic wr, input logic bcp, input logic [1:0] addr,
                      input logic [15:0] din, input logic ps, input logic pp, input logic clr,
                      input logic chk, input logic [15:0] eo, input logic [3:0] el,
                      input logic ee, input string nm);
    exp_t e;
    vst_en = en; vst_write = wr; vst_bcp_write = bcp; vst_address = addr;
    vst_in = din; push = ps; pop = pp; clear = clr;
    e.name = nm; e.chk_out = chk; e.out = eo; e.lvl = el; e.err = ee;
    q.push_back(e);
    @(negedge clk);
    vst_en = 1'b0; vst_write = 1'b0; vst_bcp_write = 1'b0;
    push = 1'b0; pop = 1'b0; clear = 1'b0;
  endtask

  task automatic rd(input logic [1:0] addr, input logic [15:0] eo, input logic [3:0] el, input string nm);
    step(1'b1, 1'b0, 1'b0, addr, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, eo, el, 1'b0, nm);
  endtask

  // Monitor: one expectation per driven cycle, checked just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        if (e.chk_out) cmp({e.name, ":vst_out"}, 32'(vst_out), 32'(e.out));
        cmp({e.name, ":level"}, 32'(level), 32'(e.lvl));
        cmp({e.name, ":full"}, 32'(full), 32'(e.lvl == 4'd8));
        cmp({e.name, ":empty"}, 32'(empty), 32'(e.lvl == 4'd0));
        cmp({e.name, ":stack_err"}, 32'(stack_err), 32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    cmp("rst_level", 32'(level), 32'd0);
    cmp("rst_empty", 32'(empty), 32'd1);
    cmp("rst_out", 32'(vst_out), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    rd(2'd0, 16'hFFFF, 4'd0, "rst_free");
    rd(2'd1, 16'h0000, 4'd0, "rst_assign");
    rd(2'd2, 16'h0000, 4'd0, "rst_force");
    rd(2'd3, 16'h0001, 4'd0, "rst_status");

    step(1, 1, 0, 2'd0, 16'h00F0, 0, 0, 0, 1, 16'hFFFF, 4'd0, 0, "wr_free_old");
    step(1, 0, 1, 2'd1, 16'h00FF, 0, 0, 0, 1, 16'h0000, 4'd0, 0, "bcp_assign_old");
    rd(2'd1, 16'h00F0, 4'd0, "bcp_assign");
    step(1, 0, 1, 2'd0, 16'h0030, 0, 0, 0, 1, 16'h00F0, 4'd0, 0, "bcp_free_old");
    rd(2'd0, 16'h00C0, 4'd0, "bcp_free");

    step(1, 1, 0, 2'd1, 16'h0001, 0, 0, 0, 1, 16'h00F0, 4'd0, 0, "wr_assign1");
    step(0, 0, 0, 2'd0, 16'h0000, 1, 0, 0, 0, 16'h0000, 4'd1, 0, "push1");
    step(1, 1, 0, 2'd1, 16'h0003, 1, 0, 0, 1, 16'h0001, 4'd2, 0, "push2_wr");
    step(1, 0, 0, 2'd1, 16'h0000, 0, 1, 0, 1, 16'h0003, 4'd1, 0, "pop1_rd");
    step(1, 1, 0, 2'd1, 16'hFFFF, 0, 1, 0, 1, 16'h0001, 4'd0, 0, "pop2_wr_drop");
    rd(2'd1, 16'h0001, 4'd0, "restored_assign");
    rd(2'd0, 16'h00C0, 4'd0, "restored_free");

    for (int i = 1; i <= 8; i++)
      step(0, 0, 0, 2'd0, 16'h0000, 1, 0, 0, 0, 16'h0000, 4'(i), 0, "push_fill");
    rd(2'd3, 16'h0022, 4'd8, "status_full");
    step(0, 0, 0, 2'd0, 16'h0000, 1, 0, 0, 1, 16'h0022, 4'd8, 1, "push_overflow");
    step(0, 0, 0, 2'd0, 16'h0000, 0, 0, 0, 1, 16'h0022, 4'd8, 0, "err_pulse_end");

    for (int i = 7; i >= 0; i--)
      step(0, 0, 0, 2'd0, 16'h0000, 0, 1, 0, 0, 16'h0000, 4'(i), 0, "pop_drain");
    step(1, 0, 0, 2'd3, 16'h0000, 0, 1, 0, 1, 16'h0001, 4'd0, 1, "pop_empty");
    rd(2'd1, 16'h0001, 4'd0, "pop_empty_assign");
    rd(2'd0, 16'h00C0, 4'd0, "pop_empty_free");

    step(0, 0, 0, 2'd0, 16'h0000, 1, 0, 0, 0, 16'h0000, 4'd1, 0, "push_l1");
    step(0, 0, 0, 2'd0, 16'h0000, 1, 1, 0, 0, 16'h0000, 4'd1, 1, "push_pop_both");
    step(0, 0, 0, 2'd0, 16'h0000, 0, 0, 0, 0, 16'h0000, 4'd1, 0, "both_err_end");

    step(1, 0, 1, 2'd2, 16'h0005, 0, 0, 0, 1, 16'h0000, 4'd1, 0, "bcp_force_old");
    rd(2'd2, 16'h0005, 4'd1, "bcp_force");
    step(1, 1, 0, 2'd3, 16'hFFFF, 0, 0, 0, 1, 16'h0004, 4'd1, 0, "wr_status_drop");
    rd(2'd3, 16'h0004, 4'd1, "status_l1");

    step(1, 1, 0, 2'd1, 16'h1234, 1, 0, 1, 1, 16'h0000, 4'd0, 0, "clear");
    rd(2'd0, 16'hFFFF, 4'd0, "clr_free");
    rd(2'd1, 16'h0000, 4'd0, "clr_assign");
    rd(2'd2, 16'h0000, 4'd0, "clr_force");
    rd(2'd3, 16'h0001, 4'd0, "clr_status");

    rd(2'd0, 16'hFFFF, 4'd0, "pre_arst_free");
    step(0, 0, 0, 2'd0, 16'h0000, 1, 0, 0, 0, 16'h0000, 4'd1, 0, "pre_arst_push");
    push = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    cmp("arst_out", 32'(vst_out), 32'd0);
    cmp("arst_level", 32'(level), 32'd0);
    cmp("arst_empty", 32'(empty), 32'd1);
    cmp("arst_full", 32'(full), 32'd0);
    cmp("arst_err", 32'(stack_err), 32'd0);
    push = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd(2'd1, 16'h0000, 4'd0, "post_arst_assign");
    rd(2'd3, 16'h0001, 4'd0, "post_arst_status");

    repeat (2) @(negedge clk);
    cmp("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
